// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between the simplified master and the SRAM slave.
interface ahb_lite_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [3:0]            WAIT_CFG;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;

  modport master (
    output HSEL, HADDR, HWRITE, HWDATA, WAIT_CFG,
    input  HRDATA, HREADY
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HWDATA, WAIT_CFG,
    output HRDATA, HREADY
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// Word-addressed AHB-Lite slave over an internal memory, with a per-transfer
// programmable number of wait states and pipelined address/data phases.
module ahb_lite_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_AW     = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_sram_slave_if.slave  bus
);

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned DEPTH  = 2 ** MEM_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [MEM_AW-1:0]   addr_q,  addr_d;
  logic                write_q, write_d;
  logic [WCNT_W-1:0]   wcnt_q,  wcnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hready;
  logic                  capture;
  logic                  wr_en;
  logic                  rd_en;
  logic                  unused_haddr_bits;

  assign haddr             = bus.HADDR;
  assign unused_haddr_bits = ^{haddr[ADDR_WIDTH-1:MEM_AW+2], haddr[1:0]};

  assign hready  = (state_q != ST_WAIT);
  assign capture = hready && bus.HSEL;
  assign wr_en   = (state_q == ST_DATA) && write_q;
  assign rd_en   = (state_q == ST_DATA) && !write_q;

  // State and latched transfer attributes
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE, ST_DATA: begin
        if (capture) begin
          addr_d  = haddr[MEM_AW+1:2];
          write_d = bus.HWRITE;
          wcnt_d  = bus.WAIT_CFG;
          state_d = (bus.WAIT_CFG == '0) ? ST_DATA : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        // Last wait cycle; <= also guards against an unreachable zero count
        if (wcnt_q <= WCNT_W'(1)) begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory is intentionally not reset; reset forces IDLE so no write fires
  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      mem[addr_q] <= bus.HWDATA;
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRDATA = rd_en ? mem[addr_q] : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench: directed vector table, corner sequences and random
// transfers checked cycle by cycle against a transaction-level memory model.
module tb_ahb_lite_sram_slave;

  logic HCLK = 1'b0;
  logic HRESET;

  ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_lite_sram_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_AW    (8)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [256];

  // Transfer whose final data-phase cycle is still owed to the bus
  bit          pend;
  bit          pend_wr;
  logic [31:0] pend_data;
  logic [31:0] pend_exp;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  wcfg;
    logic [31:0] data;
    int          gap;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_cycle(input bit sel, input logic [31:0] addr, input bit wr,
                          input logic [3:0] wcfg, input logic [31:0] wdata,
                          input bit exp_rdy, input logic [31:0] exp_rd, input string tag);
    @(negedge HCLK);
    bus.HSEL     = sel;
    bus.HADDR    = addr;
    bus.HWRITE   = wr;
    bus.WAIT_CFG = wcfg;
    bus.HWDATA   = wdata;
    #1;
    check({tag, " HREADY"}, 32'(bus.HREADY), 32'(exp_rdy));
    check({tag, " HRDATA"}, bus.HRDATA, exp_rd);
  endtask

  // A cycle with HREADY expected high; completes the pending transfer if any
  task automatic slot_cycle(input bit sel, input logic [31:0] addr, input bit wr,
                            input logic [3:0] wcfg, input string tag);
    logic [31:0] wd;
    logic [31:0] rd;
    wd = (pend && pend_wr) ? pend_data : $urandom;
    rd = (pend && !pend_wr) ? pend_exp : 32'h0;
    do_cycle(sel, addr, wr, wcfg, wd, 1'b1, rd, tag);
    pend = 1'b0;
  endtask

  task automatic flush();
    slot_cycle(1'b0, $urandom, 1'($urandom), 4'($urandom), "idle");
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [3:0] wcfg,
                      input logic [31:0] data, input int gap, input logic [31:0] exp_rd,
                      input string tag);
    for (int g = 0; g < gap; g++) begin
      slot_cycle(1'b0, $urandom, 1'($urandom), 4'($urandom), {tag, " gap"});
    end
    slot_cycle(1'b1, addr, wr, wcfg, {tag, " addr"});
    // Address-side inputs are garbage during waits; write data must be held
    for (int i = 0; i < int'(wcfg); i++) begin
      do_cycle(1'($urandom), $urandom, 1'($urandom), 4'($urandom),
               wr ? data : $urandom, 1'b0, 32'h0, {tag, " wait"});
    end
    pend      = 1'b1;
    pend_wr   = wr;
    pend_data = data;
    pend_exp  = exp_rd;
    if (wr) model[addr[9:2]] = data;
  endtask

  initial begin
    pend         = 1'b0;
    pend_wr      = 1'b0;
    pend_data    = '0;
    pend_exp     = '0;
    HRESET       = 1'b1;
    bus.HSEL     = 1'b0;
    bus.HADDR    = '0;
    bus.HWRITE   = 1'b0;
    bus.WAIT_CFG = '0;
    bus.HWDATA   = '0;

    #1;
    check("reset HREADY", 32'(bus.HREADY), 32'h1);
    check("reset HRDATA", bus.HRDATA, 32'h0);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    // Fill memory so every later read has a defined reference value
    for (int i = 0; i < 256; i++) begin
      xfer(1'b1, 32'(i * 4), 4'd0, $urandom, 0, 32'h0, "fill");
    end
    flush();

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'd0, 32'h1234_5678, 0, 32'h0,         "zw_wr"};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'd0, 32'h0,         0, 32'h1234_5678, "zw_rd"};
    vecs[2]  = '{1'b1, 32'h0000_0020, 4'd0, 32'hCAFE_F00D, 1, 32'h0,         "ws_wr"};
    vecs[3]  = '{1'b0, 32'h0000_0020, 4'd3, 32'h0,         1, 32'hCAFE_F00D, "ws3_rd"};
    vecs[4]  = '{1'b1, 32'h0000_0000, 4'd2, 32'h0000_0001, 1, 32'h0,         "pipe_wr"};
    vecs[5]  = '{1'b0, 32'h0000_0000, 4'd0, 32'h0,         0, 32'h0000_0001, "pipe_rd"};
    vecs[6]  = '{1'b1, 32'h0000_0400, 4'd1, 32'h0000_BEEF, 1, 32'h0,         "wrap_wr"};
    vecs[7]  = '{1'b0, 32'h0000_0000, 4'd0, 32'h0,         1, 32'h0000_BEEF, "wrap_rd"};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 4'd0, 32'h0000_0055, 0, 32'h0,         "top_wr"};
    vecs[9]  = '{1'b0, 32'h0000_0400, 4'd0, 32'h0,         0, 32'h0000_BEEF, "top_plus4"};
    vecs[10] = '{1'b1, 32'hFFFF_F00B, 4'd15, 32'h5A5A_A5A5, 0, 32'h0,        "hibits_wr"};
    vecs[11] = '{1'b0, 32'h0000_0008, 4'd1, 32'h0,         0, 32'h5A5A_A5A5, "hibits_rd"};
    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wcfg, vecs[i].data, vecs[i].gap,
           vecs[i].exp, vecs[i].name);
    end
    flush();

    // Deselected write-looking traffic must not touch word 2
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 32'h8, 1'b1, 4'($urandom), $urandom, 1'b1, 32'h0, "desel");
    end
    xfer(1'b0, 32'h8, 4'd0, 32'h0, 0, model[2], "desel_rd");
    flush();

    // Reset in the middle of a waited write drops the write
    xfer(1'b1, 32'hC, 4'd0, 32'h1111_2222, 0, 32'h0, "pre3");
    flush();
    slot_cycle(1'b1, 32'hC, 1'b1, 4'd4, "rst_wr addr");
    do_cycle(1'b0, 32'h0, 1'b0, 4'd0, 32'hAAAA_0000, 1'b0, 32'h0, "rst_wr wait");
    @(negedge HCLK);
    bus.HSEL   = 1'b0;
    bus.HWDATA = 32'hAAAA_0000;
    HRESET     = 1'b1;
    #1;
    check("rst async HREADY", 32'(bus.HREADY), 32'h1);
    check("rst async HRDATA", bus.HRDATA, 32'h0);
    do_cycle(1'b1, 32'h10, 1'b1, 4'd0, 32'hAAAA_0000, 1'b1, 32'h0, "in_reset");
    @(negedge HCLK);
    HRESET = 1'b0;
    bus.HSEL = 1'b0;
    xfer(1'b0, 32'hC, 4'd2, 32'h0, 0, 32'h1111_2222, "rst_rd3");
    flush();

    // Random pipelined traffic against the memory model
    for (int t = 0; t < 400; t++) begin
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  wcfg;
      int          gap;
      wr   = 1'($urandom);
      addr = $urandom;
      wcfg = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      xfer(wr, addr, wcfg, $urandom, gap, wr ? 32'h0 : model[addr[9:2]], "rand");
    end
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
